// File: rtl/data_ram.sv
// data_ram: word-addressed data memory for the memory stage.
// A request is accepted in IDLE, waits WAIT_STATES cycles, is performed on the
// access edge and completes with a one-cycle ready pulse. Read data, ready,
// busy and error are all registered. Per-byte write enables; addresses with any
// bit set at or above DEPTH_LOG2 are rejected with error.
// Optional feature macro: DATA_RAM_INIT_EN -- preload words 0..5 with
// 7, 5, 2, 4, 8, 4 and every other word with 0. Without it the array powers
// up undefined. Reset never touches the array in either build.
module data_ram #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_LOG2  = 5,
  parameter int WAIT_STATES = 1
) (
  input  logic                    clock,
  input  logic                    nReset,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   writeData,
  input  logic [DATA_WIDTH/8-1:0] byteEnable,
  input  logic                    memWrite,
  input  logic                    memRead,
  output logic [DATA_WIDTH-1:0]   readData,
  output logic                    ready,
  output logic                    busy,
  output logic                    error
);

  localparam int         LANES      = DATA_WIDTH / 8;
  localparam int         WORDS      = 1 << DEPTH_LOG2;
  localparam logic [2:0] WAIT_LOAD  = 3'(WAIT_STATES);
  localparam logic       ZERO_WAIT  = (WAIT_STATES == 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  nextState_s;
  logic [2:0]              count_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [DATA_WIDTH-1:0]   wdata_r;
  logic [LANES-1:0]        be_r;
  logic                    wr_r;
  logic                    rd_r;

  logic [ADDR_WIDTH-1:0]   opAddr_s;
  logic [DATA_WIDTH-1:0]   opData_s;
  logic [LANES-1:0]        opBe_s;
  logic                    opWr_s;
  logic                    opRd_s;
  logic                    request_s;
  logic                    access_s;
  logic                    outOfRange_s;
  logic                    commitWrite_s;
  logic [DEPTH_LOG2-1:0]   memIdx_s;

  logic [DATA_WIDTH-1:0]   mem [WORDS];

  // True when any address bit at position DEPTH_LOG2 or above is set.
  function automatic logic isOutOfRange(input logic [ADDR_WIDTH-1:0] a);
    isOutOfRange = ((a >> DEPTH_LOG2) != '0) ? 1'b1 : 1'b0;
  endfunction

`ifdef DATA_RAM_INIT_EN
  // Power-up contents: a small fixed table, everything else zero.
  initial begin
    for (int i = 0; i < WORDS; i++) begin
      mem[i] = '0;
    end
    mem[0] = DATA_WIDTH'(7);
    mem[1] = DATA_WIDTH'(5);
    mem[2] = DATA_WIDTH'(2);
    mem[3] = DATA_WIDTH'(4);
    mem[4] = DATA_WIDTH'(8);
    mem[5] = DATA_WIDTH'(4);
  end
`else
  // Without the preload the array is left undefined until written.
`endif

  // Operand select: with zero wait states the access happens on the accept
  // edge, so the live inputs are used in IDLE; otherwise the latched copy.
  always_comb begin
    opAddr_s  = addr_r;
    opData_s  = wdata_r;
    opBe_s    = be_r;
    opWr_s    = wr_r;
    opRd_s    = rd_r;
    request_s = memWrite | memRead;
    if (state_r == IDLE) begin
      opAddr_s = address;
      opData_s = writeData;
      opBe_s   = byteEnable;
      opWr_s   = memWrite;
      opRd_s   = memRead;
    end else begin
      opAddr_s = addr_r;
      opData_s = wdata_r;
      opBe_s   = be_r;
      opWr_s   = wr_r;
      opRd_s   = rd_r;
    end
  end

  // Next-state logic and access-edge decode.
  always_comb begin
    nextState_s = state_r;
    access_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (request_s) begin
          if (ZERO_WAIT) begin
            nextState_s = DONE;
            access_s    = 1'b1;
          end else begin
            nextState_s = WAIT;
          end
        end else begin
          nextState_s = IDLE;
        end
      end
      WAIT: begin
        if (count_r <= 3'd1) begin
          nextState_s = DONE;
          access_s    = 1'b1;
        end else begin
          nextState_s = WAIT;
        end
      end
      DONE: begin
        nextState_s = IDLE;
      end
      default: begin
        nextState_s = IDLE;
      end
    endcase
  end

  // Access qualifiers: range check, word index and write commit (never
  // while reset is asserted, so an abandoned write cannot land).
  always_comb begin
    outOfRange_s  = isOutOfRange(opAddr_s);
    memIdx_s      = opAddr_s[DEPTH_LOG2-1:0];
    commitWrite_s = access_s & opWr_s & ~outOfRange_s & nReset;
  end

  // FSM state register.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_r <= IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Request capture and wait counter.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      count_r <= 3'd0;
      addr_r  <= '0;
      wdata_r <= '0;
      be_r    <= '0;
      wr_r    <= 1'b0;
      rd_r    <= 1'b0;
    end else if (state_r == IDLE && request_s) begin
      count_r <= WAIT_LOAD;
      addr_r  <= address;
      wdata_r <= writeData;
      be_r    <= byteEnable;
      wr_r    <= memWrite;
      rd_r    <= memRead;
    end else if (state_r == WAIT && count_r != 3'd0) begin
      count_r <= count_r - 3'd1;
    end
  end

  // Registered outputs: read result and status on the access edge, ready
  // and busy follow the state being entered.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      readData <= '0;
      error    <= 1'b0;
      ready    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      ready <= (nextState_s == DONE) ? 1'b1 : 1'b0;
      busy  <= (nextState_s == WAIT) ? 1'b1 : 1'b0;
      if (access_s) begin
        error <= outOfRange_s | (opWr_s & opRd_s);
        if (outOfRange_s) begin
          readData <= '0;
        end else if (opRd_s && !opWr_s) begin
          readData <= mem[memIdx_s];
        end
      end
    end
  end

  // Memory array write, lane by lane; deliberately not reset.
  always_ff @(posedge clock) begin
    for (int i = 0; i < LANES; i++) begin
      if (commitWrite_s && opBe_s[i]) begin
        mem[memIdx_s][8*i +: 8] <= opData_s[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_ram.sv
// Directed bench for data_ram: one instance with default parameters and one
// with WAIT_STATES = 0. Words under test are written through the ports first
// so the checks do not depend on the preload build option.
module tb_data_ram;

  logic        clock;
  logic        nReset;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [3:0]  byteEnable;
  logic        memWriteA, memReadA, memWriteB, memReadB;
  logic [31:0] readDataA, readDataB;
  logic        readyA, busyA, errorA, readyB, busyB, errorB;

  int compared;
  int mismatched;

  logic [31:0] rdata;
  logic        err;
  int          lat;
  int          busyCnt;

  data_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(5), .WAIT_STATES(1)) dutA (
    .clock(clock), .nReset(nReset), .address(address), .writeData(writeData),
    .byteEnable(byteEnable), .memWrite(memWriteA), .memRead(memReadA),
    .readData(readDataA), .ready(readyA), .busy(busyA), .error(errorA)
  );

  data_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(5), .WAIT_STATES(0)) dutB (
    .clock(clock), .nReset(nReset), .address(address), .writeData(writeData),
    .byteEnable(byteEnable), .memWrite(memWriteB), .memRead(memReadB),
    .readData(readDataB), .ready(readyB), .busy(busyB), .error(errorB)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request, hold it until ready is seen, drop it in the ready cycle.
  task automatic doRequest(input bit useB, input bit wr, input bit rd,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] be);
    bit got;
    @(negedge clock);
    address    = addr;
    writeData  = data;
    byteEnable = be;
    if (useB) begin
      memWriteB = wr;
      memReadB  = rd;
    end else begin
      memWriteA = wr;
      memReadA  = rd;
    end
    got     = 1'b0;
    lat     = 0;
    busyCnt = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      lat++;
      if (useB ? busyB : busyA) busyCnt++;
      if (useB ? readyB : readyA) begin
        got   = 1'b1;
        rdata = useB ? readDataB : readDataA;
        err   = useB ? errorB : errorA;
      end
    end
    memWriteA = 1'b0;
    memReadA  = 1'b0;
    memWriteB = 1'b0;
    memReadB  = 1'b0;
    if (!got) begin
      checkValue("ready_timeout", 32'd0, 32'd1);
      rdata = 32'hxxxxxxxx;
      err   = 1'bx;
    end
  endtask

  logic [31:0] preload [6];

  initial begin
    compared   = 0;
    mismatched = 0;
    preload[0] = 32'd7; preload[1] = 32'd5; preload[2] = 32'd2;
    preload[3] = 32'd4; preload[4] = 32'd8; preload[5] = 32'd4;
    nReset = 1'b0;
    address = 32'd0; writeData = 32'd0; byteEnable = 4'd0;
    memWriteA = 1'b0; memReadA = 1'b0; memWriteB = 1'b0; memReadB = 1'b0;
    repeat (3) @(negedge clock);

    checkValue("rst_readData", readDataA, 32'd0);
    checkValue("rst_ready", {31'd0, readyA}, 32'd0);
    checkValue("rst_busy", {31'd0, busyA}, 32'd0);
    checkValue("rst_error", {31'd0, errorA}, 32'd0);
    checkValue("rst_readyB", {31'd0, readyB}, 32'd0);
    checkValue("rst_busyB", {31'd0, busyB}, 32'd0);
    nReset = 1'b1;

    for (int i = 0; i < 6; i++) begin
      doRequest(1'b0, 1'b1, 1'b0, 32'(i), preload[i], 4'hF);
    end
    doRequest(1'b0, 1'b1, 1'b0, 32'd9, 32'd0, 4'hF);
    doRequest(1'b1, 1'b1, 1'b0, 32'd0, 32'd7, 4'hF);

    // plain read with latency and busy width
    doRequest(1'b0, 1'b0, 1'b1, 32'd3, 32'd0, 4'h0);
    checkValue("rd3_data", rdata, 32'd4);
    checkValue("rd3_error", {31'd0, err}, 32'd0);
    checkValue("rd3_latency", 32'(lat), 32'd2);
    checkValue("rd3_busy", 32'(busyCnt), 32'd1);

    // partial write, readData must hold the previous read
    doRequest(1'b0, 1'b1, 1'b0, 32'd9, 32'hDEADBEEF, 4'b0101);
    checkValue("wr9_error", {31'd0, err}, 32'd0);
    checkValue("wr9_hold", rdata, 32'd4);
    doRequest(1'b0, 1'b0, 1'b1, 32'd9, 32'd0, 4'h0);
    checkValue("rd9_data", rdata, 32'h00AD00EF);

    // out of range read and write
    doRequest(1'b0, 1'b0, 1'b1, 32'd32, 32'd0, 4'h0);
    checkValue("rd32_error", {31'd0, err}, 32'd1);
    checkValue("rd32_data", rdata, 32'd0);
    doRequest(1'b0, 1'b1, 1'b0, 32'd32, 32'hFFFFFFFF, 4'hF);
    checkValue("wr32_error", {31'd0, err}, 32'd1);
    doRequest(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 4'h0);
    checkValue("rd0_after_wr32", rdata, 32'd7);

    // simultaneous write and read
    doRequest(1'b0, 1'b1, 1'b1, 32'd2, 32'h11, 4'hF);
    checkValue("both_error", {31'd0, err}, 32'd1);
    doRequest(1'b0, 1'b0, 1'b1, 32'd2, 32'd0, 4'h0);
    checkValue("rd2_data", rdata, 32'h11);
    checkValue("rd2_error", {31'd0, err}, 32'd0);

    // reset during WAIT abandons the write
    @(negedge clock);
    address = 32'd1; writeData = 32'h55; byteEnable = 4'hF; memWriteA = 1'b1;
    @(posedge clock);
    #2;
    checkValue("pre_rst_busy", {31'd0, busyA}, 32'd1);
    nReset = 1'b0;
    #1;
    checkValue("midrst_readData", readDataA, 32'd0);
    checkValue("midrst_ready", {31'd0, readyA}, 32'd0);
    checkValue("midrst_busy", {31'd0, busyA}, 32'd0);
    checkValue("midrst_error", {31'd0, errorA}, 32'd0);
    memWriteA = 1'b0;
    @(negedge clock);
    nReset = 1'b1;
    doRequest(1'b0, 1'b0, 1'b1, 32'd1, 32'd0, 4'h0);
    checkValue("rd1_after_rst", rdata, 32'd5);

    // zero wait states
    doRequest(1'b1, 1'b0, 1'b1, 32'd0, 32'd0, 4'h0);
    checkValue("b_rd0_data", rdata, 32'd7);
    checkValue("b_rd0_latency", 32'(lat), 32'd1);
    checkValue("b_rd0_busy", 32'(busyCnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
